// File: rtl/parameterized_reg_file_mp.sv
// Multi-port register file with a hardware clear engine and registered read ports.
// Optional macro WRITE_BYPASS_EN: same-edge write data is forwarded to matching read ports.
module parameterized_reg_file_mp #(
    parameter int WIDTH         = 32,
    parameter int NUM_REGISTERS = 32,
    parameter int ADR_BUS_WIDTH = 5,
    parameter int NUM_WPORTS    = 2,
    parameter int NUM_RPORTS    = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clr_req,
    input  logic [NUM_WPORTS-1:0]            we,
    input  logic [NUM_WPORTS*ADR_BUS_WIDTH-1:0] waddress,
    input  logic [NUM_WPORTS*WIDTH-1:0]      wdata,
    input  logic [NUM_RPORTS*ADR_BUS_WIDTH-1:0] raddress,
    output logic [NUM_RPORTS*WIDTH-1:0]      rdata,
    output logic                             ready,
    output logic                             wr_err
);

    localparam int IDX_W = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1;
    localparam logic [ADR_BUS_WIDTH:0]   LP_NREG = (ADR_BUS_WIDTH + 1)'(NUM_REGISTERS);
    localparam logic [ADR_BUS_WIDTH-1:0] LP_LAST = ADR_BUS_WIDTH'(NUM_REGISTERS - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    function automatic logic in_range(input logic [ADR_BUS_WIDTH-1:0] a);
        return ({1'b0, a} < LP_NREG);
    endfunction

    function automatic logic [IDX_W-1:0] to_idx(input logic [ADR_BUS_WIDTH-1:0] a);
        return a[IDX_W-1:0];
    endfunction

    state_t                     r_state;
    logic [ADR_BUS_WIDTH-1:0]   r_clr_cnt;
    logic                       r_ready;
    logic                       r_wr_err;
    logic [NUM_RPORTS*WIDTH-1:0] r_rdata;
    logic [WIDTH-1:0]           r_mem [NUM_REGISTERS];

    logic                       w_accept;
    logic [ADR_BUS_WIDTH-1:0]   w_waddr   [NUM_WPORTS];
    logic [WIDTH-1:0]           w_wdata   [NUM_WPORTS];
    logic [NUM_WPORTS-1:0]      w_wr_en;
    logic [NUM_WPORTS-1:0]      w_wr_oor;
    logic [ADR_BUS_WIDTH-1:0]   w_raddr   [NUM_RPORTS];
    logic [WIDTH-1:0]           w_rd_next [NUM_RPORTS];

    // A clear request in READY cancels every write presented in the same cycle.
    assign w_accept = (r_state == ST_READY) && !clr_req;

    always_comb begin
        for (int i = 0; i < NUM_WPORTS; i++) begin
            w_waddr[i]  = waddress[i*ADR_BUS_WIDTH +: ADR_BUS_WIDTH];
            w_wdata[i]  = wdata[i*WIDTH +: WIDTH];
            w_wr_en[i]  = w_accept && we[i] && in_range(w_waddr[i]);
            w_wr_oor[i] = w_accept && we[i] && !in_range(w_waddr[i]);
        end
    end

    always_comb begin
        for (int j = 0; j < NUM_RPORTS; j++) begin
            w_raddr[j]   = raddress[j*ADR_BUS_WIDTH +: ADR_BUS_WIDTH];
            w_rd_next[j] = '0;
            if ((r_state == ST_READY) && in_range(w_raddr[j])) begin
                w_rd_next[j] = r_mem[to_idx(w_raddr[j])];
            end
`ifdef WRITE_BYPASS_EN
            // Ascending scan so the highest enabled port wins, matching the array update.
            for (int i = 0; i < NUM_WPORTS; i++) begin
                if (w_wr_en[i] && (w_waddr[i] == w_raddr[j])) begin
                    w_rd_next[j] = w_wdata[i];
                end
            end
`endif
        end
    end

    // Storage has no reset; the clear engine is what zeroes it.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[to_idx(r_clr_cnt)] <= '0;
        end else begin
            for (int i = 0; i < NUM_WPORTS; i++) begin
                if (w_wr_en[i]) begin
                    r_mem[to_idx(w_waddr[i])] <= w_wdata[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else begin
            for (int j = 0; j < NUM_RPORTS; j++) begin
                r_rdata[j*WIDTH +: WIDTH] <= w_rd_next[j];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            r_ready   <= 1'b0;
            r_wr_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_wr_err <= 1'b0;
                    if (r_clr_cnt == LP_LAST) begin
                        r_state <= ST_READY;
                        r_ready <= 1'b1;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + ADR_BUS_WIDTH'(1);
                    end
                end
                ST_READY: begin
                    r_wr_err <= |w_wr_oor;
                    if (clr_req) begin
                        r_state   <= ST_CLEAR;
                        r_clr_cnt <= '0;
                        r_ready   <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_CLEAR;
                    r_clr_cnt <= '0;
                    r_ready   <= 1'b0;
                    r_wr_err  <= 1'b0;
                end
            endcase
        end
    end

    assign rdata  = r_rdata;
    assign ready  = r_ready;
    assign wr_err = r_wr_err;

endmodule

// File: tb/tb_parameterized_reg_file_mp.sv
// Scoreboard bench for parameterized_reg_file_mp: default 32x32 instance plus a 64-bit x 16 instance.
module tb_parameterized_reg_file_mp;

    localparam int W  = 32;
    localparam int N  = 32;
    localparam int A  = 5;
    localparam int NW = 2;
    localparam int NR = 2;
    localparam int W2 = 64;
    localparam int N2 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset, clr_req, clr_req2;
    logic [NW-1:0]      we, we2;
    logic [NW*A-1:0]    waddress, waddress2;
    logic [NW*W-1:0]    wdata;
    logic [NW*W2-1:0]   wdata2;
    logic [NR*A-1:0]    raddress, raddress2;
    logic [NR*W-1:0]    rdata;
    logic [NR*W2-1:0]   rdata2;
    logic               ready, ready2, wr_err, wr_err2;

    int total = 0;
    int bad   = 0;

    logic [W-1:0]  model  [N];
    logic [W2-1:0] model2 [N2];
    logic [W-1:0]  sb_q  [$];
    logic [W2-1:0] sb2_q [$];

    parameterized_reg_file_mp #(
        .WIDTH(W), .NUM_REGISTERS(N), .ADR_BUS_WIDTH(A), .NUM_WPORTS(NW), .NUM_RPORTS(NR)
    ) dut (
        .clk(clk), .reset(reset), .clr_req(clr_req), .we(we), .waddress(waddress),
        .wdata(wdata), .raddress(raddress), .rdata(rdata), .ready(ready), .wr_err(wr_err)
    );

    parameterized_reg_file_mp #(
        .WIDTH(W2), .NUM_REGISTERS(N2), .ADR_BUS_WIDTH(A), .NUM_WPORTS(NW), .NUM_RPORTS(NR)
    ) dut2 (
        .clk(clk), .reset(reset), .clr_req(clr_req2), .we(we2), .waddress(waddress2),
        .wdata(wdata2), .raddress(raddress2), .rdata(rdata2), .ready(ready2), .wr_err(wr_err2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd1(input int a0, input int a1);
        raddress = {A'(a1), A'(a0)};
        sb_q.push_back(a0 < N ? model[a0] : '0);
        sb_q.push_back(a1 < N ? model[a1] : '0);
    endtask

    task automatic rd2(input int a0, input int a1);
        raddress2 = {A'(a1), A'(a0)};
        sb2_q.push_back(a0 < N2 ? model2[a0] : '0);
        sb2_q.push_back(a1 < N2 ? model2[a1] : '0);
    endtask

    task automatic wr1(input logic [NW-1:0] en, input int a0, input logic [W-1:0] d0,
                       input int a1, input logic [W-1:0] d1);
        we       = en;
        waddress = {A'(a1), A'(a0)};
        wdata    = {d1, d0};
    endtask

    task automatic test_reset();
        int c1, c2;
        logic [W-1:0]  e;
        logic [W2-1:0] e2;
        logic nz;
        reset = 1'b1;
        tick();
        tick();
        total++;
        if ({ready, ready2, wr_err, wr_err2} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b exp=0000", {ready, ready2, wr_err, wr_err2});
        end
        total++;
        if ((rdata !== '0) || (rdata2 !== '0)) begin
            bad++; $display("FAIL reset_rdata got=%h/%h exp=0", rdata, rdata2);
        end
        reset = 1'b0;
        c1 = -1; c2 = -1; nz = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (ready && c1 < 0) c1 = k;
            if (ready2 && c2 < 0) c2 = k;
            if ((rdata !== '0) || (rdata2 !== '0)) nz = 1'b1;
        end
        total++;
        if (c1 != N) begin bad++; $display("FAIL reset_clear_len got=%0d exp=%0d", c1, N); end
        total++;
        if (c2 != N2) begin bad++; $display("FAIL reset_clear_len2 got=%0d exp=%0d", c2, N2); end
        total++;
        if (nz !== 1'b0) begin bad++; $display("FAIL reset_rdata_clear got=nonzero exp=0"); end
        for (int i = 0; i < N; i++) model[i] = '0;
        for (int i = 0; i < N2; i++) model2[i] = '0;
        for (int a = 0; a < N; a += 2) begin
            rd1(a, a + 1);
            rd2(a % N2, (a + 1) % N2);
            tick();
            for (int j = 0; j < NR; j++) begin
                e = sb_q.pop_front();
                total++;
                if (rdata[j*W +: W] !== e) begin
                    bad++; $display("FAIL reset_zero addr=%0d got=%h exp=%h", a + j, rdata[j*W +: W], e);
                end
                e2 = sb2_q.pop_front();
                total++;
                if (rdata2[j*W2 +: W2] !== e2) begin
                    bad++; $display("FAIL reset_zero2 port%0d got=%h exp=%h", j, rdata2[j*W2 +: W2], e2);
                end
            end
        end
    endtask

    task automatic test_write();
        logic [W-1:0] e;
        wr1(2'b01, 1, 32'h256, 0, 32'h0);
        tick();
        model[1] = 32'h256;
        wr1(2'b10, 0, 32'h0, 2, 32'h23);
        tick();
        model[2] = 32'h23;
        we = '0;
        rd1(1, 2);
        tick();
        for (int j = 0; j < NR; j++) begin
            e = sb_q.pop_front();
            total++;
            if (rdata[j*W +: W] !== e) begin
                bad++; $display("FAIL write_read port%0d got=%h exp=%h", j, rdata[j*W +: W], e);
            end
        end
        total++;
        if (wr_err !== 1'b0) begin bad++; $display("FAIL write_no_err got=%b exp=0", wr_err); end
    endtask

    task automatic test_priority();
        logic [W-1:0] e;
        wr1(2'b11, 3, 32'hAAAA, 3, 32'h5555);
        tick();
        model[3] = 32'h5555;
        wr1(2'b11, 5, 32'h1111_0005, 6, 32'h2222_0006);
        tick();
        model[5] = 32'h1111_0005;
        model[6] = 32'h2222_0006;
        we = '0;
        rd1(3, 3);
        tick();
        rd1(5, 6);
        for (int j = 0; j < NR; j++) begin
            e = sb_q.pop_front();
            total++;
            if (rdata[j*W +: W] !== e) begin
                bad++; $display("FAIL priority port%0d got=%h exp=%h", j, rdata[j*W +: W], e);
            end
        end
        tick();
        for (int j = 0; j < NR; j++) begin
            e = sb_q.pop_front();
            total++;
            if (rdata[j*W +: W] !== e) begin
                bad++; $display("FAIL dual_write port%0d got=%h exp=%h", j, rdata[j*W +: W], e);
            end
        end
    endtask

    task automatic test_wr_err();
        logic [W2-1:0] e2;
        we2 = 2'b01; waddress2 = {A'(0), A'(4)}; wdata2 = {64'h0, 64'h0123_4567_89AB_CDEF};
        tick();
        model2[4] = 64'h0123_4567_89AB_CDEF;
        we2 = 2'b11; waddress2 = {A'(7), A'(31)}; wdata2 = {64'h77, 64'hDEAD};
        tick();
        model2[7] = 64'h77;
        we2 = '0;
        total++;
        if (wr_err2 !== 1'b1) begin bad++; $display("FAIL wr_err_pulse got=%b exp=1", wr_err2); end
        rd2(15, 7);
        tick();
        total++;
        if (wr_err2 !== 1'b0) begin bad++; $display("FAIL wr_err_single got=%b exp=0", wr_err2); end
        rd2(31, 4);
        for (int j = 0; j < NR; j++) begin
            e2 = sb2_q.pop_front();
            total++;
            if (rdata2[j*W2 +: W2] !== e2) begin
                bad++; $display("FAIL wr_err_array port%0d got=%h exp=%h", j, rdata2[j*W2 +: W2], e2);
            end
        end
        tick();
        for (int j = 0; j < NR; j++) begin
            e2 = sb2_q.pop_front();
            total++;
            if (rdata2[j*W2 +: W2] !== e2) begin
                bad++; $display("FAIL oor_read port%0d got=%h exp=%h", j, rdata2[j*W2 +: W2], e2);
            end
        end
    endtask

    task automatic test_bypass();
        logic [W-1:0] e;
        logic [W-1:0] exp_rd;
`ifdef WRITE_BYPASS_EN
        exp_rd = 32'h4567;
`else
        exp_rd = model[4];
`endif
        wr1(2'b01, 4, 32'h4567, 0, 32'h0);
        raddress = {A'(4), A'(4)};
        sb_q.push_back(exp_rd);
        sb_q.push_back(exp_rd);
        tick();
        model[4] = 32'h4567;
        we = '0;
        rd1(4, 4);
        for (int j = 0; j < NR; j++) begin
            e = sb_q.pop_front();
            total++;
            if (rdata[j*W +: W] !== e) begin
                bad++; $display("FAIL bypass_same_edge port%0d got=%h exp=%h", j, rdata[j*W +: W], e);
            end
        end
        tick();
        for (int j = 0; j < NR; j++) begin
            e = sb_q.pop_front();
            total++;
            if (rdata[j*W +: W] !== e) begin
                bad++; $display("FAIL bypass_after port%0d got=%h exp=%h", j, rdata[j*W +: W], e);
            end
        end
    endtask

    task automatic test_clear();
        logic [W-1:0] e;
        for (int a = 0; a < N; a += 2) begin
            wr1(2'b11, a, 32'hC0DE_0000 | W'(a), a + 1, 32'hC0DE_0000 | W'(a + 1));
            tick();
            model[a]     = 32'hC0DE_0000 | W'(a);
            model[a + 1] = 32'hC0DE_0000 | W'(a + 1);
        end
        we = '0;
        rd1(0, N - 1);
        tick();
        for (int j = 0; j < NR; j++) begin
            e = sb_q.pop_front();
            total++;
            if (rdata[j*W +: W] !== e) begin
                bad++; $display("FAIL fill port%0d got=%h exp=%h", j, rdata[j*W +: W], e);
            end
        end
        clr_req = 1'b1;
        wr1(2'b01, 0, 32'hFFFF_FFFF, 0, 32'h0);
        tick();
        clr_req = 1'b0;
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL clear_ready_drop got=%b exp=0", ready); end
        for (int k = 1; k <= N; k++) begin
            wr1(2'b11, k % N, 32'hBAD0_0000 | W'(k), (k + 7) % N, 32'hBAD1_0000 | W'(k));
            raddress = {A'((k + 3) % N), A'(k % N)};
            clr_req = (k == 5);
            tick();
            total++;
            if (rdata !== '0) begin bad++; $display("FAIL clear_rdata k=%0d got=%h exp=0", k, rdata); end
            total++;
            if (ready !== (k == N)) begin
                bad++; $display("FAIL clear_ready k=%0d got=%b exp=%b", k, ready, (k == N));
            end
        end
        we = '0;
        clr_req = 1'b0;
        for (int i = 0; i < N; i++) model[i] = '0;
        for (int a = 0; a < N; a += 2) begin
            rd1(a, a + 1);
            tick();
            for (int j = 0; j < NR; j++) begin
                e = sb_q.pop_front();
                total++;
                if (rdata[j*W +: W] !== e) begin
                    bad++; $display("FAIL clear_zero addr=%0d got=%h exp=%h", a + j, rdata[j*W +: W], e);
                end
            end
        end
    endtask

    task automatic test_reset_midclear();
        int c1, c2;
        logic [W-1:0]  e;
        logic [W2-1:0] e2;
        wr1(2'b01, 20, 32'hBEEF, 0, 32'h0);
        tick();
        model[20] = 32'hBEEF;
        we = '0;
        raddress2 = {A'(7), A'(7)};
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        total++;
        if (rdata2[W2-1:0] !== model2[7]) begin
            bad++; $display("FAIL pre_reset_read got=%h exp=%h", rdata2[W2-1:0], model2[7]);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({ready, ready2} !== 2'b00) begin
            bad++; $display("FAIL async_ready got=%b exp=00", {ready, ready2});
        end
        total++;
        if ((rdata !== '0) || (rdata2 !== '0)) begin
            bad++; $display("FAIL async_rdata got=%h/%h exp=0", rdata, rdata2);
        end
        tick();
        tick();
        reset = 1'b0;
        c1 = -1; c2 = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (ready && c1 < 0) c1 = k;
            if (ready2 && c2 < 0) c2 = k;
        end
        total++;
        if (c1 != N) begin bad++; $display("FAIL restart_clear_len got=%0d exp=%0d", c1, N); end
        total++;
        if (c2 != N2) begin bad++; $display("FAIL restart_clear_len2 got=%0d exp=%0d", c2, N2); end
        for (int i = 0; i < N; i++) model[i] = '0;
        for (int i = 0; i < N2; i++) model2[i] = '0;
        rd1(20, 4);
        rd2(7, 4);
        tick();
        for (int j = 0; j < NR; j++) begin
            e = sb_q.pop_front();
            total++;
            if (rdata[j*W +: W] !== e) begin
                bad++; $display("FAIL restart_zero port%0d got=%h exp=%h", j, rdata[j*W +: W], e);
            end
            e2 = sb2_q.pop_front();
            total++;
            if (rdata2[j*W2 +: W2] !== e2) begin
                bad++; $display("FAIL restart_zero2 port%0d got=%h exp=%h", j, rdata2[j*W2 +: W2], e2);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; clr_req = 1'b0; clr_req2 = 1'b0;
        we = '0; waddress = '0; wdata = '0; raddress = '0;
        we2 = '0; waddress2 = '0; wdata2 = '0; raddress2 = '0;
        #2;
        test_reset();
        test_write();
        test_priority();
        test_wr_err();
        test_bypass();
        test_clear();
        test_reset_midclear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
